rv32m_muldiv_tagged: RTL and testbench
======================================

RV32M_MULDIV_TAGGED -- requirements
Module: rv32m_muldiv_tagged

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal value 32 only for RV32 builds, generic arithmetic elsewhere.
REQ-002 Parameter TAG_W, default 5, width of the issue tag (ROB index) carried with each operation.
REQ-003 Parameter MUL_STAGES, default 3, multiplier pipeline depth; legal range 1..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 flush  in  1  kill all in-flight operations (branch mispredict / exception).
REQ-007 in_valid  in  1  operation offered this cycle.
REQ-008 in_ready  out  1  unit accepts offered operation this cycle.
REQ-009 in_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 in_rs1, in_rs2  in  XLEN each  source operands.
REQ-011 in_tag  in  TAG_W  tag returned unchanged with the result.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes result; transfer when out_valid && out_ready.
REQ-014 out_result  out  XLEN; out_tag  out  TAG_W  result and its tag.
REQ-015 busy  out  1  any multiplier stage valid or divider not IDLE.

Function
REQ-016 Accept = in_valid && in_ready; in_op[2]=0 is mul-class, in_op[2]=1 is div-class.
REQ-017 in_ready = !flush && (mul-class ? multiplier stage 1 can advance this cycle : divider in IDLE).
REQ-018 Multiplier: fully pipelined, one accept per cycle; result at output exactly MUL_STAGES cycles after accept when not stalled.
REQ-019 MUL returns low XLEN bits; MULH high bits signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned; product computed at 2*XLEN bits.
REQ-020 Multiplier stall: when last stage valid and not transferred, all stages hold; bubbles ahead of a stalled stage are compressed (a stage advances if the next stage is empty or advancing).
REQ-021 Divider FSM states IDLE, CALC, DONE; IDLE -> CALC on normal accept; CALC runs exactly XLEN restoring iterations, one per cycle, then -> DONE; DONE -> IDLE on output transfer.
REQ-022 Normal divide latency: out_valid asserts XLEN+1 cycles after accept when output free.
REQ-023 Signed ops divide magnitudes; quotient negated when operand signs differ; remainder takes sign of rs1.
REQ-024 Divide by zero: IDLE -> DONE directly (1-cycle latency); quotient = all ones, remainder = rs1.
REQ-025 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, DIV/REM): IDLE -> DONE directly; quotient = rs1, remainder = 0.
REQ-026 Only one divide in flight; mul-class ops accepted freely while divider in CALC/DONE.
REQ-027 Output arbitration: multiplier last stage has priority; divider waits in DONE while multiplier result present.
REQ-028 out_valid = mul last-stage valid OR divider in DONE; out_result/out_tag from the selected source.
REQ-029 Backpressure: while out_valid && !out_ready, out_result and out_tag remain stable; the presented result is not replaced until transferred, except by flush.
REQ-030 Results may return out of issue order; tag is the only ordering information.
REQ-031 flush: next cycle all multiplier stage valids = 0, divider = IDLE, out_valid = 0; no accept in the flush cycle; flush overrides simultaneous accept and transfer.
REQ-032 in_valid with in_ready = 0 has no side effect.

Reset
REQ-033 rst=1 at a clock edge: all multiplier valids 0, divider IDLE, out_valid 0, busy 0, out_result 0, out_tag 0.
REQ-034 Reset mid-operation discards all in-flight work; in_ready = 0 while rst asserted; first accept possible on the cycle after rst deasserts.

Verification
REQ-035 MUL 10*5 tag 3, out_ready=1 -> out_result 50, out_tag 3, exactly 3 cycles after accept.
REQ-036 MUL 2*3, 4*5, 10*10 on consecutive cycles, tags 1,2,3 -> 6, 20, 100 on three consecutive cycles; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 DIV 100/4 tag 7 -> busy 1 next cycle, result 25 tag 7 after 33 cycles; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each 1 cycle after accept.
REQ-039 DIV 100/2 tag 4 then MUL 10*10 tag 5 two cycles later -> MUL result 100 tag 5 returns first; second DIV offered while busy sees in_ready 0; later DIV result 50 tag 4.
REQ-040 out_ready held 0 with MUL and DIV results pending -> output stable, no loss; flush mid-CALC -> out_valid 0 next cycle, no result emitted, busy 0.

Source files
------------

// File: rtl/rv32m_muldiv_tagged_if.sv
// Issue/result handshake bundle for the tagged RV32M multiply/divide unit.
interface rv32m_muldiv_tagged_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output flush, in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );
    modport slave (
        input  flush, in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/rv32m_muldiv_tagged.sv
// RV32M execution unit: pipelined multiplier plus iterative restoring divider,
// sharing one tagged result port; results may return out of order.
module rv32m_muldiv_tagged #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int MUL_STAGES = 3
) (
    input logic                   clk,
    input logic                   rst,
    rv32m_muldiv_tagged_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } slot_t;

    div_state_t            state, state_nx;
    logic [MUL_STAGES:1]   vld_pipe, can_load, eff;
    slot_t [MUL_STAGES:1]  slot;
    logic                  full;
    logic                  accept, mul_acc, div_acc, mul_out, div_done, div_xfer;

    // ---------------- multiplier ----------------
    logic                   a_sgn, b_sgn;
    logic signed [XLEN:0]   ma, mb;
    logic signed [2*XLEN-1:0] mp;
    logic [XLEN-1:0]        mul_res;

    assign a_sgn   = (bus.in_op[1:0] == 2'b01) || (bus.in_op[1:0] == 2'b10);
    assign b_sgn   = (bus.in_op[1:0] == 2'b01);
    assign ma      = {a_sgn & bus.in_rs1[XLEN-1], bus.in_rs1};
    assign mb      = {b_sgn & bus.in_rs2[XLEN-1], bus.in_rs2};
    assign mp      = (2*XLEN)'(ma) * (2*XLEN)'(mb);
    assign mul_res = (bus.in_op[1:0] == 2'b00) ? mp[XLEN-1:0] : mp[2*XLEN-1:XLEN];

    // A parked divider result counts as occupying the last slot so a mul can
    // never displace a result already presented under backpressure.
    always_comb begin
        eff = vld_pipe;
        eff[MUL_STAGES] = vld_pipe[MUL_STAGES] | div_done;
        can_load = '0;
        full = 1'b1;
        for (int i = 1; i <= MUL_STAGES; i++) begin
            full = 1'b1;
            for (int j = i; j <= MUL_STAGES; j++) full = full & eff[j];
            can_load[i] = bus.out_ready | ~full;
        end
    end

    assign bus.in_ready = !rst && !bus.flush &&
                          (bus.in_op[2] ? (state == IDLE) : can_load[1]);
    assign accept   = bus.in_valid && bus.in_ready;
    assign mul_acc  = accept && !bus.in_op[2];
    assign div_acc  = accept &&  bus.in_op[2];
    assign mul_out  = vld_pipe[MUL_STAGES];
    assign div_done = (state == DONE);
    assign div_xfer = div_done && !mul_out && bus.out_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            slot     <= '0;
        end else if (bus.flush) begin
            vld_pipe <= '0;
        end else begin
            for (int i = MUL_STAGES; i >= 2; i--) begin
                if (can_load[i]) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    slot[i]     <= slot[i-1];
                end
            end
            if (can_load[1]) begin
                vld_pipe[1] <= mul_acc;
                slot[1]     <= {mul_res, bus.in_tag};
            end
        end
    end

    // ---------------- divider ----------------
    logic             signed_op, rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  dq, dr, dd, dres, q_nx, r_nx;
    logic [TAG_W-1:0] dtag;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, is_rem, ge, last;
    logic [XLEN:0]    rs, diff;

    assign signed_op = !bus.in_op[0];
    assign rs1_neg   = signed_op & bus.in_rs1[XLEN-1];
    assign rs2_neg   = signed_op & bus.in_rs2[XLEN-1];
    assign abs_a     = rs1_neg ? -bus.in_rs1 : bus.in_rs1;
    assign abs_b     = rs2_neg ? -bus.in_rs2 : bus.in_rs2;
    assign div_zero  = (bus.in_rs2 == '0);
    assign div_ovf   = signed_op && (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (bus.in_rs2 == '1);

    assign rs   = {dr, dq[XLEN-1]};
    assign diff = rs - {1'b0, dd};
    assign ge   = ~diff[XLEN];
    assign q_nx = {dq[XLEN-2:0], ge};
    assign r_nx = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
    assign last = (cnt == CW'(XLEN-1));

    always_ff @(posedge clk) begin
        if (rst || bus.flush) state <= IDLE;
        else                  state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (div_acc) state_nx = (div_zero || div_ovf) ? DONE : CALC;
            CALC: if (last)    state_nx = DONE;
            DONE: if (div_xfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq <= '0; dr <= '0; dd <= '0; dres <= '0; dtag <= '0; cnt <= '0;
            neg_q <= 1'b0; neg_r <= 1'b0; is_rem <= 1'b0;
        end else if (div_acc) begin
            dq     <= abs_a;
            dr     <= '0;
            dd     <= abs_b;
            cnt    <= '0;
            neg_q  <= rs1_neg ^ rs2_neg;
            neg_r  <= rs1_neg;
            is_rem <= bus.in_op[1];
            dtag   <= bus.in_tag;
            if (div_zero)     dres <= bus.in_op[1] ? bus.in_rs1 : '1;
            else if (div_ovf) dres <= bus.in_op[1] ? '0 : bus.in_rs1;
        end else if (state == CALC) begin
            dq  <= q_nx;
            dr  <= r_nx;
            cnt <= cnt + CW'(1);
            if (last)
                dres <= is_rem ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
        end
    end

    // ---------------- output ----------------
    assign bus.out_valid  = mul_out | div_done;
    assign bus.out_result = mul_out ? slot[MUL_STAGES].res :
                            div_done ? dres : '0;
    assign bus.out_tag    = mul_out ? slot[MUL_STAGES].tag :
                            div_done ? dtag : '0;
    assign bus.busy       = (|vld_pipe) || (state != IDLE);
endmodule

// File: tb/tb_rv32m_muldiv_tagged.sv
// Directed bench for rv32m_muldiv_tagged: tag-keyed reference model checked
// on every transfer, plus literal expectations for the documented vectors.
module tb_rv32m_muldiv_tagged;
    localparam int XLEN = 32, TAG_W = 5, MS = 3;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                           DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32m_muldiv_tagged_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();
    rv32m_muldiv_tagged #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    typedef struct { int tag; logic [31:0] res; int cyc; } ret_t;
    ret_t log_q[$];
    logic [31:0] exp_v [int];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int si, sj;
        logic ovf;
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ua = {32'b0, a};       ub = {32'b0, b};
        si = a; sj = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = 64'd0;
        case (op)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(si / sj);
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(si % sj);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Compare process: every transfer is checked against the model; a stalled
    // output must be held unchanged on the following cycle.
    logic prev_stall = 1'b0, prev_flush = 1'b0;
    logic [31:0] prev_res = '0;
    logic [4:0]  prev_tag = '0;
    int t_c;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
            exp_v.delete();
        end else begin
            if (prev_stall && !prev_flush) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_result", bus.out_result, prev_res);
                chk("hold_tag", bus.out_tag, prev_tag);
            end
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                t_c = int'(bus.out_tag);
                chk("tag_pending", exp_v.exists(t_c), 1);
                if (exp_v.exists(t_c)) begin
                    chk("model_result", bus.out_result, exp_v[t_c]);
                    exp_v.delete(t_c);
                end
                log_q.push_back('{t_c, bus.out_result, cyc});
            end
            if (bus.flush) exp_v.delete();
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_flush = bus.flush;
            prev_res   = bus.out_result;
            prev_tag   = bus.out_tag;
        end
    end

    // All driving tasks start and end at posedge+1.
    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, int tag, output int acc);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs1 = a; bus.in_rs2 = b;
        bus.in_tag = TAG_W'(tag);
        acc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = cyc;
                exp_v[tag] = ref_calc(op, a, b);
                break;
            end
        end
        if (acc < 0) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(int n, int budget, string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clk); #1; k++;
        end
        if (log_q.size() < n) chk({name, "_timeout"}, log_q.size(), n);
    endtask

    task automatic run1(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        int tag, logic [31:0] exp_res, int lat);
        int acc;
        log_q.delete();
        issue(op, a, b, tag, acc);
        @(negedge clk);
        chk({name, "_busy"}, bus.busy, 1);
        @(posedge clk); #1;
        wait_log(1, 60, name);
        chk({name, "_res"}, log_q[0].res, exp_res);
        chk({name, "_tag"}, log_q[0].tag, tag);
        chk({name, "_lat"}, log_q[0].cyc - acc, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, ad, am, r0;
        bus.flush = 0; bus.in_valid = 0; bus.in_op = MUL; bus.in_rs1 = 0;
        bus.in_rs2 = 0; bus.in_tag = 0; bus.out_ready = 1;

        // reset: offered op must not be accepted
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        r0 = cyc;

        log_q.delete();
        issue(MUL, 10, 5, 3, a0);
        chk("first_accept_cycle", a0, r0);
        wait_log(1, 20, "mul10x5");
        chk("mul10x5_res", log_q[0].res, 50);
        chk("mul10x5_tag", log_q[0].tag, 3);
        chk("mul10x5_lat", log_q[0].cyc - a0, 3);

        // back-to-back multiplies
        log_q.delete();
        issue(MUL, 2, 3, 1, a0);
        issue(MUL, 4, 5, 2, a1);
        issue(MUL, 10, 10, 3, a2);
        chk("b2b_accept1", a1 - a0, 1);
        chk("b2b_accept2", a2 - a0, 2);
        wait_log(3, 20, "b2b");
        chk("b2b_res0", log_q[0].res, 6);
        chk("b2b_res1", log_q[1].res, 20);
        chk("b2b_res2", log_q[2].res, 100);
        chk("b2b_tag0", log_q[0].tag, 1);
        chk("b2b_tag2", log_q[2].tag, 3);
        chk("b2b_lat", log_q[0].cyc - a0, 3);
        chk("b2b_consec1", log_q[1].cyc - log_q[0].cyc, 1);
        chk("b2b_consec2", log_q[2].cyc - log_q[0].cyc, 2);

        log_q.delete();
        issue(MULH, 32'h8000_0000, 32'h8000_0000, 10, a0);
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 11, a0);
        issue(MULHSU, 32'hFFFF_FFFF, 2, 12, a0);
        issue(MUL, 32'hFFFF_FFFD, 7, 13, a0);
        wait_log(4, 20, "mulh");
        chk("mulh_res", log_q[0].res, 32'h4000_0000);
        chk("mulhu_res", log_q[1].res, 32'hFFFF_FFFE);
        chk("mulhsu_res", log_q[2].res, 32'hFFFF_FFFF);
        chk("mul_neg_res", log_q[3].res, 32'hFFFF_FFEB);

        // divides, normal and special
        run1("div100_4", DIV, 100, 4, 7, 25, 33);
        run1("div_m7_2", DIV, 32'hFFFF_FFF9, 2, 8, 32'hFFFF_FFFD, 33);
        run1("rem_m7_2", REM, 32'hFFFF_FFF9, 2, 9, 32'hFFFF_FFFF, 33);
        run1("divu5_0", DIVU, 5, 0, 10, 32'hFFFF_FFFF, 1);
        run1("rem5_0", REM, 5, 0, 11, 5, 1);
        run1("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 12, 32'h8000_0000, 1);
        run1("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 13, 0, 1);
        run1("divu_big", DIVU, 32'hFFFF_FFFF, 3, 14, 32'h5555_5555, 33);
        run1("remu100_7", REMU, 100, 7, 15, 2, 33);

        // mul overtakes an in-flight divide; second divide is refused
        log_q.delete();
        issue(DIV, 100, 2, 4, ad);
        idle(1);
        issue(MUL, 10, 10, 5, am);
        chk("ooo_mul_accept", am - ad, 2);
        bus.in_valid = 1'b1; bus.in_op = DIV; bus.in_rs1 = 9; bus.in_rs2 = 3; bus.in_tag = 6;
        @(negedge clk);
        chk("div_busy_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_log(2, 60, "ooo");
        chk("ooo_first_tag", log_q[0].tag, 5);
        chk("ooo_first_res", log_q[0].res, 100);
        chk("ooo_second_tag", log_q[1].tag, 4);
        chk("ooo_second_res", log_q[1].res, 50);
        chk("ooo_div_lat", log_q[1].cyc - ad, 33);

        // backpressure: mul presented first, divide waits behind it
        log_q.delete();
        bus.out_ready = 1'b0;
        issue(MUL, 6, 7, 20, a0);
        idle(3);
        issue(DIVU, 20, 0, 21, a1);
        idle(8);
        @(negedge clk);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_tag", bus.out_tag, 20);
        chk("bp_no_xfer", log_q.size(), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_log(2, 10, "bp");
        chk("bp_res0", log_q[0].res, 42);
        chk("bp_tag1", log_q[1].tag, 21);
        chk("bp_res1", log_q[1].res, 32'hFFFF_FFFF);

        // backpressure: divide presented first, mul arrives later
        log_q.delete();
        bus.out_ready = 1'b0;
        issue(DIVU, 7, 0, 22, a0);
        idle(2);
        issue(MUL, 3, 3, 23, a1);
        idle(6);
        bus.out_ready = 1'b1;
        wait_log(2, 10, "bp2");
        chk("bp2_count", log_q.size(), 2);

        // flush mid-CALC with a multiply also in flight
        log_q.delete();
        issue(DIV, 100, 3, 24, a0);
        idle(5);
        issue(MUL, 2, 2, 25, a1);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = MUL; bus.in_tag = 26;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_busy", bus.busy, 0);
        @(posedge clk); #1;
        idle(45);
        chk("flush_no_result", log_q.size(), 0);
        run1("post_flush_mul", MUL, 7, 8, 26, 56, 3);

        // reset mid-divide discards the work
        log_q.delete();
        issue(DIV, 50, 5, 27, a0);
        idle(3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        idle(40);
        chk("midrst_no_result", log_q.size(), 0);

        chk("scoreboard_empty", exp_v.num(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
